// File: rtl/muldiv_seq_unit_pkg.sv
// Shared ALU-control codes and multiply/divide sequencer encodings.
package muldiv_seq_unit_pkg;

  localparam logic [4:0] ALUCtrl_ADD   = 5'd2;
  localparam logic [4:0] ALUCtrl_MULT  = 5'd24;
  localparam logic [4:0] ALUCtrl_MULTU = 5'd25;
  localparam logic [4:0] ALUCtrl_DIV   = 5'd26;
  localparam logic [4:0] ALUCtrl_DIVU  = 5'd27;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; used for operand magnitude and result sign.
module muldiv_signfix #(
  parameter int N = 32
) (
  input  logic         neg,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative shift-add multiply / restoring divide engine owning HI and LO.
//
// state   | meaning
// MD_IDLE | waiting for start with a mul/div code
// MD_CALC | one multiply or divide iteration per cycle, WIDTH cycles
// MD_FIX  | sign correction; the edge leaving it writes HI/LO
// MD_DONE | done pulse; a new start here runs back-to-back
module muldiv_seq_unit
  import muldiv_seq_unit_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  src_a,
  input  logic [WIDTH-1:0]  src_b,
  input  logic              abort,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd_a, opnd_b;
  logic               op_div, neg_q, neg_r, dz;
  logic               done_q, dbz_q;

  logic               code_ok, code_div, code_signed;
  logic               accept, last_iter, finish;
  logic [WIDTH-1:0]   abs_a, abs_b, fix_q, fix_r;
  logic [2*WIDTH-1:0] fix_p;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH:0]     sum, trial;
  logic [WIDTH-1:0]   diff;
  logic               trial_ge;

  always_comb begin
    code_ok     = 1'b0;
    code_div    = 1'b0;
    code_signed = 1'b0;
    case (alu_ctrl)
      CTRL_W'(ALUCtrl_MULT):  begin code_ok = 1'b1; code_signed = 1'b1; end
      CTRL_W'(ALUCtrl_MULTU): begin code_ok = 1'b1; end
      CTRL_W'(ALUCtrl_DIV):   begin code_ok = 1'b1; code_div = 1'b1; code_signed = 1'b1; end
      CTRL_W'(ALUCtrl_DIVU):  begin code_ok = 1'b1; code_div = 1'b1; end
      default: ;
    endcase
  end

  assign accept    = start && code_ok && !abort && ((state == MD_IDLE) || (state == MD_DONE));
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign finish    = (state == MD_FIX) && !abort;

  muldiv_signfix #(.N(WIDTH)) u_abs_a (
    .neg(code_signed & src_a[WIDTH-1]), .din(src_a), .dout(abs_a));
  muldiv_signfix #(.N(WIDTH)) u_abs_b (
    .neg(code_signed & src_b[WIDTH-1]), .din(src_b), .dout(abs_b));
  muldiv_signfix #(.N(2*WIDTH)) u_fix_p (
    .neg(neg_q), .din(acc), .dout(fix_p));
  muldiv_signfix #(.N(WIDTH)) u_fix_q (
    .neg(neg_q), .din(acc[WIDTH-1:0]), .dout(fix_q));
  muldiv_signfix #(.N(WIDTH)) u_fix_r (
    .neg(neg_r), .din(acc[2*WIDTH-1:WIDTH]), .dout(fix_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = MD_CALC;
      MD_CALC: begin
        if (abort)          state_nxt = MD_IDLE;
        else if (last_iter) state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = abort ? MD_IDLE : MD_DONE;
      MD_DONE: state_nxt = accept ? MD_CALC : MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == MD_CALC) || (state == MD_FIX);
    done        = done_q;
    div_by_zero = dbz_q;
  end

  // Multiply: HI half accumulates, LO half holds the multiplier shifting out.
  // Divide: HI half is the partial remainder, LO half shifts dividend out / quotient in.
  always_comb begin
    acc_nxt  = acc;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_a} : {(WIDTH+1){1'b0}});
    trial    = acc[2*WIDTH-1:WIDTH-1];
    trial_ge = (trial >= {1'b0, opnd_b});
    diff     = trial[WIDTH-1:0] - opnd_b;
    if (op_div) begin
      if (trial_ge) acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
      else          acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    res_hi = fix_p[2*WIDTH-1:WIDTH];
    res_lo = fix_p[WIDTH-1:0];
    if (op_div) begin
      if (dz) begin
        res_hi = opnd_a;
        res_lo = '1;
      end else begin
        res_hi = fix_r;
        res_lo = fix_q;
      end
    end
  end

  // For divides opnd_a keeps the raw dividend, which is the divide-by-zero HI value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      opnd_a <= '0;
      opnd_b <= '0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (accept) begin
      acc    <= {{WIDTH{1'b0}}, (code_div ? abs_a : abs_b)};
      cnt    <= '0;
      opnd_a <= code_div ? src_a : abs_a;
      opnd_b <= abs_b;
      op_div <= code_div;
      neg_q  <= code_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      neg_r  <= code_signed & code_div & src_a[WIDTH-1];
      dz     <= code_div & (src_b == '0);
    end else if (state == MD_CALC) begin
      acc <= acc_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (finish) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (!busy) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= finish;
      dbz_q  <= finish & dz;
    end
  end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: vector table plus abort/reset/handshake sequences.
module tb_muldiv_seq_unit;
  import muldiv_seq_unit_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, hi_we, lo_we;
  logic [4:0]    alu_ctrl;
  logic [W-1:0]  src_a, src_b, wdata;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi, lo;

  logic          start8;
  logic [4:0]    ctrl8;
  logic [7:0]    a8, b8, wdata8;
  logic          abort8, hi_we8, lo_we8;
  logic          busy8, done8, dbz8;
  logic [7:0]    hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq_unit #(.WIDTH(W), .CTRL_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .abort(abort), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo));

  muldiv_seq_unit #(.WIDTH(8), .CTRL_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .alu_ctrl(ctrl8),
    .src_a(a8), .src_b(b8), .abort(abort8), .hi_we(hi_we8), .lo_we(lo_we8),
    .wdata(wdata8), .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .hi(hi8), .lo(lo8));

  typedef struct {
    string        name;
    logic [4:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
    logic         edz;
    logic         b2b;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; start is seen by the next posedge (the accept edge).
  task automatic launch(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Entered in cycle 1 (first negedge after the accept edge); returns in the done cycle.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic watch_idle(input string nm, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk(nm, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt;

    vecs[0]  = '{"multu_max",  ALUCtrl_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
    vecs[1]  = '{"mult_neg",   ALUCtrl_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0};
    vecs[2]  = '{"div_neg",    ALUCtrl_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[3]  = '{"divu_big",   ALUCtrl_DIVU,  32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 1'b0, 1'b0};
    vecs[4]  = '{"divu_zero",  ALUCtrl_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5]  = '{"div_zero",   ALUCtrl_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6]  = '{"div_posneg", ALUCtrl_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0};
    vecs[7]  = '{"mult_minsq", ALUCtrl_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
    vecs[8]  = '{"multu_x16",  ALUCtrl_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0};
    vecs[9]  = '{"div_min_m1", ALUCtrl_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1};
    vecs[10] = '{"divu_b2b",   ALUCtrl_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 1'b0};
    vecs[11] = '{"div_negneg", ALUCtrl_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    alu_ctrl = '0; src_a = '0; src_b = '0; wdata = '0;
    start8 = 1'b0; ctrl8 = '0; a8 = '0; b8 = '0; wdata8 = '0;
    abort8 = 1'b0; hi_we8 = 1'b0; lo_we8 = 1'b0;

    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    chk("rst_hi",   {32'd0, hi}, 64'd0);
    chk("rst_lo",   {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      chk({vecs[i].name, "_latency"}, 64'(lat), 64'(W + 2));
      chk({vecs[i].name, "_busycyc"}, 64'(bcnt), 64'(W + 1));
      chk({vecs[i].name, "_hi"}, {32'd0, hi}, {32'd0, vecs[i].ehi});
      chk({vecs[i].name, "_lo"}, {32'd0, lo}, {32'd0, vecs[i].elo});
      chk({vecs[i].name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, vecs[i].edz});
      if (!vecs[i].b2b) begin
        @(negedge clk);
        chk({vecs[i].name, "_done_pulse"}, {62'd0, done, div_by_zero}, 64'd0);
        chk({vecs[i].name, "_hi_held"}, {32'd0, hi}, {32'd0, vecs[i].ehi});
      end
    end

    // mthi in the same cycle as an accepted start: lands now, overwritten by result
    hi_we = 1'b1;
    wdata = 32'h0000ABCD;
    launch(ALUCtrl_MULTU, 32'd3, 32'd4);
    hi_we = 1'b0;
    chk("mthi_with_start", {32'd0, hi}, 64'h0000ABCD);
    wait_done(lat, bcnt);
    chk("mthi_overwrite_hi", {32'd0, hi}, 64'd0);
    chk("mthi_overwrite_lo", {32'd0, lo}, 64'd12);
    @(negedge clk);

    // preload, then abort at cycle 10 with a stray start and mthi while busy
    hi_we = 1'b1; wdata = 32'h00001234;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h00005678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("preload_hi", {32'd0, hi}, 64'h1234);
    chk("preload_lo", {32'd0, lo}, 64'h5678);
    launch(ALUCtrl_MULT, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    start = 1'b1; alu_ctrl = ALUCtrl_DIVU; hi_we = 1'b1; wdata = 32'h0000FFFF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("busy_mid_calc", {63'd0, busy}, 64'd1);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    watch_idle("abort_no_done", 40);
    chk("abort_hi", {32'd0, hi}, 64'h1234);
    chk("abort_lo", {32'd0, lo}, 64'h5678);

    // abort together with start in IDLE
    start = 1'b1; abort = 1'b1; alu_ctrl = ALUCtrl_MULT; src_a = 32'd2; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {63'd0, busy}, 64'd0);
    watch_idle("abort_start_no_done", 40);

    // non mul/div code is ignored
    start = 1'b1; alu_ctrl = ALUCtrl_ADD;
    @(negedge clk);
    start = 1'b0;
    chk("add_busy", {63'd0, busy}, 64'd0);
    watch_idle("add_no_done", 40);
    chk("add_hi_kept", {32'd0, hi}, 64'h1234);

    // asynchronous reset in the middle of CALC
    launch(ALUCtrl_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_dbz",  {63'd0, div_by_zero}, 64'd0);
    chk("arst_hi",   {32'd0, hi}, 64'd0);
    chk("arst_lo",   {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=8 instance
    start8 = 1'b1; ctrl8 = ALUCtrl_MULTU; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (done8) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    chk("w8_latency", 64'(lat), 64'd10);
    chk("w8_hi", {56'd0, hi8}, 64'hFE);
    chk("w8_lo", {56'd0, lo8}, 64'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
